// File: rtl/weight_rom_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : weight_rom_sequencer_pkg
//  Brief  : Shared conv-layer constants, FSM encoding and set-base helper.
//  Rev    : 1.0  initial release
// ============================================================================
package weight_rom_sequencer_pkg;

    localparam int WIDTH          = 32;
    localparam int KERNEL_SIZE    = 3;
    localparam int KK             = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WEIGHT_SET_NUM = 2;
    localparam int ADDR_W         = 5;
    localparam int SET_STRIDE     = 16;
    // One spare bit so out-of-range selections can reach the error path
    localparam int SET_W          = $clog2(WEIGHT_SET_NUM + 1);
    localparam int KIDX_W         = $clog2(KK);
    localparam int PASS_W         = 8;

    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] set_base(input logic [SET_W-1:0] sel);
        return ADDR_W'(int'(sel) * SET_STRIDE);
    endfunction

endpackage : weight_rom_sequencer_pkg
`default_nettype wire

// File: rtl/weight_rom_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module : weight_rom_sequencer_if
//  Brief  : Control, ROM and PE-array signals of the weight sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
interface weight_rom_sequencer_if;
    import weight_rom_sequencer_pkg::*;

    logic              i_start;
    logic [SET_W-1:0]  i_set_sel;
    logic [7:0]        i_repeat;
    logic              i_stall;
    logic [WIDTH-1:0]  i_rom_data;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [WIDTH-1:0]  o_weight;
    logic              o_weight_valid;
    logic              o_weight_last;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start, i_set_sel, i_repeat, i_stall, i_rom_data,
        output o_rom_addr, o_weight, o_weight_valid, o_weight_last,
               o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_set_sel, i_repeat, i_stall, i_rom_data,
        input  o_rom_addr, o_weight, o_weight_valid, o_weight_last,
               o_busy, o_done, o_err
    );

endinterface : weight_rom_sequencer_if
`default_nettype wire

// File: rtl/weight_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : weight_rom_sequencer
//  Brief  : Walks one KxK weight set of the async weight ROM for N passes,
//           registering each word toward the PE array with valid/last.
//  Rev    : 1.0  initial release
// ============================================================================
module weight_rom_sequencer
    import weight_rom_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    weight_rom_sequencer_if.slave  bus
);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [KIDX_W-1:0]  r_kidx;
    logic [PASS_W-1:0]  r_pass;
    logic [PASS_W-1:0]  r_rep;
    logic               r_fin;
    logic [WIDTH-1:0]   r_weight;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_set_ok;
    logic               w_kidx_end;
    logic               w_pass_end;

    assign w_set_ok   = (int'(bus.i_set_sel) < WEIGHT_SET_NUM);
    assign w_kidx_end = (r_kidx == KIDX_LAST);
    assign w_pass_end = (r_pass == (r_rep - PASS_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_rom_addr <= '0;
            r_kidx     <= '0;
            r_pass     <= '0;
            r_rep      <= '0;
            r_fin      <= 1'b0;
            r_weight   <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_rom_addr <= '0;
                    if (bus.i_start) begin
                        if (w_set_ok) begin
                            r_base     <= set_base(bus.i_set_sel);
                            r_rom_addr <= set_base(bus.i_set_sel);
                            r_rep      <= (bus.i_repeat == '0) ? PASS_W'(1) : bus.i_repeat;
                            r_kidx     <= '0;
                            r_pass     <= '0;
                            r_fin      <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    // Final beat is already on the output; retire the job one cycle later
                    if (r_fin) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (bus.i_stall) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_weight <= bus.i_rom_data;
                        r_valid  <= 1'b1;
                        r_last   <= w_kidx_end;
                        if (!w_kidx_end) begin
                            r_kidx     <= r_kidx + KIDX_W'(1);
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        end else if (!w_pass_end) begin
                            r_pass     <= r_pass + PASS_W'(1);
                            r_kidx     <= '0;
                            r_rom_addr <= r_base;
                        end else begin
                            r_fin <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_rom_addr <= '0;
                    r_fin      <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_rom_addr <= '0;
                    r_fin      <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rom_addr     = r_rom_addr;
    assign bus.o_weight       = r_weight;
    assign bus.o_weight_valid = r_valid;
    assign bus.o_weight_last  = r_last;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
    assign bus.o_err          = r_err;

endmodule : weight_rom_sequencer
`default_nettype wire

// File: tb/tb_weight_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_weight_rom_sequencer
//  Brief  : Self-checking bench for weight_rom_sequencer with a ROM model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_weight_rom_sequencer;
    import weight_rom_sequencer_pkg::*;

    logic clk;
    logic rst;

    weight_rom_sequencer_if bus ();

    weight_rom_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.i_rom_data = 32'h1000_0000 + 32'(bus.o_rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  rep;
        logic [4:0]  base;
        int          stall_after;
        int          stall_len;
        bit          exp_err;
        int          exp_beats;
        int          exp_busy;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[7];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_job(input logic [4:0] base, input int rep_eff);
        beat_t b;
        for (int p = 0; p < rep_eff; p++) begin
            for (int k = 0; k < KK; k++) begin
                b.data = 32'h1000_0000 + 32'(base) + 32'(k);
                b.last = (k == KK - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic check_beat(output bit got);
        beat_t e;
        got = 1'b0;
        if (bus.o_weight_valid) begin
            got = 1'b1;
            chk("beat_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat_data", bus.o_weight, e.data);
                chk("beat_last", bus.o_weight_last, e.last);
            end
        end
    endtask

    task automatic run_job(input vec_t v);
        int beats = 0, busy_cyc = 0, dones = 0, errs = 0, both = 0;
        int first_v = 0, last_v = 0, done_c = 0, addr_bad = 0, stall_bad = 0;
        int stall_left = 0;
        bit stalled = 1'b0, fin = 1'b0, got;
        logic [ADDR_W-1:0] held = '0;
        int rep_eff = (v.rep == 8'd0) ? 1 : int'(v.rep);
        if (!v.exp_err) push_job(v.base, rep_eff);
        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_set_sel = v.sel;
        bus.i_repeat  = v.rep;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.i_start   = 1'b0;
                bus.i_set_sel = ~v.sel;   // must not affect the accepted job
                bus.i_repeat  = 8'hFF;
            end
            check_beat(got);
            if (got) begin
                beats++;
                if (first_v == 0) first_v = c;
                last_v = c;
            end
            if (bus.o_busy) begin
                busy_cyc++;
                if (bus.o_rom_addr < v.base || bus.o_rom_addr > v.base + 5'd8) addr_bad++;
            end
            if (bus.o_done) begin dones++; done_c = c; end
            if (bus.o_err) errs++;
            if (bus.o_done && bus.o_err) both++;
            if (stall_left > 0) begin
                if (bus.o_weight_valid || bus.o_rom_addr !== held) stall_bad++;
                stall_left--;
                if (stall_left == 0) bus.i_stall = 1'b0;
            end else if (!stalled && v.stall_len > 0 && beats == v.stall_after) begin
                stalled    = 1'b1;
                bus.i_stall = 1'b1;
                stall_left = v.stall_len;
                held       = bus.o_rom_addr;
            end
            if (c >= 4 && !bus.o_busy && (dones > 0 || v.exp_err)) fin = 1'b1;
        end
        bus.i_stall = 1'b0;
        chk("job_finished", fin, 1);
        chk("beats", beats, v.exp_beats);
        chk("busy_cycles", busy_cyc, v.exp_busy);
        chk("done_pulses", dones, v.exp_err ? 0 : 1);
        chk("err_pulses", errs, v.exp_err ? 1 : 0);
        chk("sb_empty", sb.size(), 0);
        chk("err_done_overlap", both, 0);
        chk("addr_range", addr_bad, 0);
        if (v.stall_len > 0) chk("stall_hold", stall_bad, 0);
        if (!v.exp_err) begin
            chk("first_beat_cycle", first_v, 2);
            chk("done_after_last", done_c, last_v + 1);
            if (v.stall_len == 0) chk("back_to_back", last_v - first_v, beats - 1);
        end
        sb.delete();
    endtask

    initial begin
        int beats, dones, gap;
        bit got;

        vecs[0] = '{2'd0, 8'd1, 5'd0,  0, 0, 1'b0,  9, 11};
        vecs[1] = '{2'd1, 8'd3, 5'd16, 0, 0, 1'b0, 27, 29};
        vecs[2] = '{2'd0, 8'd1, 5'd0,  4, 3, 1'b0,  9, 14};
        vecs[3] = '{2'd2, 8'd1, 5'd0,  0, 0, 1'b1,  0,  0};
        vecs[4] = '{2'd0, 8'd0, 5'd0,  0, 0, 1'b0,  9, 11};
        vecs[5] = '{2'd1, 8'd2, 5'd16, 9, 1, 1'b0, 18, 21};
        vecs[6] = '{2'd3, 8'd5, 5'd0,  0, 0, 1'b1,  0,  0};

        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_set_sel = '0; bus.i_repeat = '0; bus.i_stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {bus.o_rom_addr, bus.o_weight, bus.o_weight_valid, bus.o_weight_last,
                              bus.o_busy, bus.o_done, bus.o_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Start held high: the second job may only begin from IDLE
        push_job(5'd0, 1);
        push_job(5'd0, 1);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_set_sel = 2'd0; bus.i_repeat = 8'd1;
        beats = 0; dones = 0; gap = 0;
        for (int c = 1; c <= 80 && dones < 2; c++) begin
            @(negedge clk);
            check_beat(got);
            if (got) beats++;
            if (bus.o_done) dones++;
            if (!bus.o_busy && dones == 1) gap++;
        end
        bus.i_start = 1'b0;
        chk("held_start_dones", dones, 2);
        chk("held_start_idle_gap", gap, 1);
        chk("held_start_beats", beats, 18);
        chk("held_start_sb_empty", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a pass
        push_job(5'd0, 1);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_set_sel = 2'd0; bus.i_repeat = 8'd1;
        beats = 0;
        for (int c = 1; c <= 40 && beats < 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_start = 1'b0;
            check_beat(got);
            if (got) beats++;
        end
        chk("rst_pre_beats", beats, 5);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_clear", {bus.o_rom_addr, bus.o_weight, bus.o_weight_valid, bus.o_weight_last,
                                bus.o_busy, bus.o_done, bus.o_err}, 0);
        sb.delete();
        dones = 0;
        repeat (2) @(negedge clk) if (bus.o_done) dones++;
        rst = 1'b0;
        repeat (3) @(negedge clk) if (bus.o_done || bus.o_busy) dones++;
        chk("rst_no_done", dones, 0);
        run_job(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_weight_rom_sequencer
`default_nettype wire
